// File: rtl/core_bus_pkg.sv
// core_bus_pkg: shared source ids and constants for the ifu/lsu bus arbiter
package core_bus_pkg;
  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} bus_src_e;
  localparam logic [3:0] BUS_BE_FULL = 4'hF;
endpackage

// File: rtl/core_bus_arbiter_id_fifo.sv
// id_fifo: 1-bit source-id fifo of outstanding transactions; push/pop in, full/empty/head out
module id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [DEPTH-1:0] mem;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp == LAST ? '0 : wp + 1'b1;
      end
      if (do_pop) rp <= rp == LAST ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: arbitrates ifu (i_*) and lsu (d_*) onto one req/gnt/rvalid port (m_*), routing in-order responses back by source id
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        m_req_o,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_gnt_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  input  logic        m_err_i
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  bus_src_e sel, lock_sel, head;
  logic locked, lock_hold, full, empty, head_bit, xfer, is_d;
  logic [SW-1:0] starve_cnt;
  assign lock_hold = locked & (lock_sel == SRC_DATA ? d_req_i : i_req_i);
  assign sel = lock_hold ? lock_sel : (d_req_i & ~(i_req_i & (starve_cnt == S_MAX))) ? SRC_DATA : SRC_INSTR;
  assign is_d = sel == SRC_DATA;
  assign m_req_o = rst_n & (i_req_i | d_req_i) & ~full;
  assign xfer = m_req_o & m_gnt_i;
  assign i_gnt_o = xfer & ~is_d;
  assign d_gnt_o = xfer & is_d;
  assign m_addr_o = is_d ? d_addr_i : i_addr_i;
  assign m_we_o = is_d & d_we_i;
  assign m_be_o = is_d ? d_be_i : BUS_BE_FULL;
  assign m_wdata_o = is_d ? d_wdata_i : '0;
  assign head = bus_src_e'(head_bit);
  assign i_rvalid_o = m_rvalid_i & ~empty & (head == SRC_INSTR);
  assign d_rvalid_o = m_rvalid_i & ~empty & (head == SRC_DATA);
  assign i_rdata_o = m_rdata_i;
  assign d_rdata_o = m_rdata_i;
  assign i_err_o = m_err_i;
  assign d_err_o = m_err_i;
  id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (xfer),
    .pop  (m_rvalid_i),
    .din  (sel),
    .full (full),
    .empty(empty),
    .head (head_bit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      locked <= 1'b0;
      lock_sel <= SRC_INSTR;
      starve_cnt <= '0;
    end else begin
      locked <= m_req_o & ~m_gnt_i;
      if (m_req_o) lock_sel <= sel;
      if (i_gnt_o) starve_cnt <= '0;
      else if (d_gnt_o & i_req_i & (starve_cnt != S_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end
  always @(posedge clk)
    if (rst_n && m_rvalid_i) assert (!empty) else $warning("core_bus_arbiter: m_rvalid_i with no outstanding transaction dropped");
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed stimulus with a response scoreboard for core_bus_arbiter
module tb_core_bus_arbiter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic i_req = 0, d_req = 0, d_we = 0, m_gnt = 0, m_rvalid = 0, m_err = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] d_be = 0;
  logic i_gnt_o, i_rvalid_o, i_err_o, d_gnt_o, d_rvalid_o, d_err_o, m_req_o, m_we_o;
  logic [31:0] i_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
  logic [3:0] m_be_o;
  typedef struct packed {logic src; logic [31:0] data; logic err;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  bit ord2[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  core_bus_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o),
    .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_err_i(m_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic samp;
    @(negedge clk);
  endtask
  task automatic rsp(input logic src, input logic [31:0] data, input logic err);
    m_rvalid = 1;
    m_rdata = data;
    m_err = err;
    exp_q.push_back({src, data, err});
  endtask
  always @(negedge clk)
    if (i_rvalid_o || d_rvalid_o) begin
      exp_t e;
      checks++;
      if (i_rvalid_o && d_rvalid_o) begin
        errors++;
        $display("FAIL rsp_both: i_rvalid=1 d_rvalid=1, expected only one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: d_rvalid=%0d with no response pending", d_rvalid_o);
      end else begin
        e = exp_q.pop_front();
        if (d_rvalid_o !== e.src || (e.src ? d_rdata_o : i_rdata_o) !== e.data || (e.src ? d_err_o : i_err_o) !== e.err) begin
          errors++;
          $display("FAIL rsp: got src=%0d data=%h err=%0d expected src=%0d data=%h err=%0d",
                   d_rvalid_o, d_rvalid_o ? d_rdata_o : i_rdata_o, d_rvalid_o ? d_err_o : i_err_o, e.src, e.data, e.err);
        end
      end
    end
  initial begin
    i_req = 1; d_req = 1; m_gnt = 1;
    samp;
    chk("rst_m_req", m_req_o, 0);
    chk("rst_i_gnt", i_gnt_o, 0);
    chk("rst_d_gnt", d_gnt_o, 0);
    chk("rst_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
    tick;
    rst_n = 1; i_req = 0; d_req = 0; m_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      i_req = k < 3; i_addr = 4 * k; m_gnt = k < 3; m_rvalid = 0;
      if (k > 0) rsp(0, 32'h1000_0000 + 4 * (k - 1), 0);
      samp;
      if (k < 3) begin
        chk("t1_i_gnt", i_gnt_o, 1);
        chk("t1_m_addr", m_addr_o, 4 * k);
      end
      if (k == 0) chk("t1_m_be_we", {m_be_o, m_we_o}, {4'hF, 1'b0});
      tick;
    end
    i_addr = 32'h100; d_addr = 32'h200; d_be = 4'h3; d_we = 0;
    i_req = 1; d_req = 1; m_gnt = 1;
    for (int k = 0; k < 11; k++) begin
      if (k == 10) begin i_req = 0; d_req = 0; m_gnt = 0; end
      m_rvalid = 0;
      if (k > 0) rsp(ord2[k - 1], 32'h2000_0000 + k, 0);
      samp;
      if (k < 10) begin
        chk("t2_d_gnt", d_gnt_o, ord2[k]);
        chk("t2_i_gnt", i_gnt_o, !ord2[k]);
        chk("t2_m_addr", m_addr_o, ord2[k] ? 32'h200 : 32'h100);
      end
      tick;
    end
    m_rvalid = 0; i_req = 1; d_req = 1; d_we = 1; m_gnt = 0;
    samp;
    chk("t3_c0_sel_d", {m_req_o, i_gnt_o, d_gnt_o, m_we_o, m_addr_o}, {4'b1001, 32'h200});
    tick;
    samp;
    chk("t3_c1_lock_d", {m_req_o, i_gnt_o, d_gnt_o, m_we_o, m_addr_o}, {4'b1001, 32'h200});
    tick;
    d_req = 0;
    samp;
    chk("t3_c2_drop", {m_req_o, i_gnt_o, d_gnt_o, m_we_o, m_addr_o}, {4'b1000, 32'h100});
    tick;
    d_req = 1; m_gnt = 1;
    samp;
    chk("t3_c3_lock_i", {i_gnt_o, d_gnt_o, m_addr_o}, {2'b10, 32'h100});
    tick;
    i_req = 0; d_req = 0; m_gnt = 0; d_we = 0;
    rsp(0, 32'h3000_0000, 0);
    samp;
    tick;
    for (int c = 0; c < 12; c++) begin
      m_rvalid = 0; m_gnt = c < 7;
      i_req = c == 1; d_req = c == 0 || (c >= 2 && c <= 6);
      if (c == 5) rsp(1, 32'h4000_0001, 0);
      if (c == 6) rsp(0, 32'h4000_0002, 0);
      if (c == 11) rsp(1, 32'h4000_0003, 0);
      samp;
      if (c == 0) chk("t4_d_gnt0", d_gnt_o, 1);
      if (c == 1) chk("t4_i_gnt1", i_gnt_o, 1);
      if (c >= 2 && c <= 5) chk("t4_full_block", {m_req_o, d_gnt_o}, 0);
      if (c == 6) chk("t4_unblock", {m_req_o, d_gnt_o}, 2'b11);
      tick;
    end
    m_rvalid = 0; d_req = 1; m_gnt = 1;
    samp;
    chk("t5_d_gnt", d_gnt_o, 1);
    tick;
    d_req = 0; i_req = 1;
    rsp(1, 32'hDEAD_BEEF, 1);
    samp;
    chk("t5_err_route", {i_gnt_o, d_rvalid_o, d_err_o, i_rvalid_o}, 4'b1110);
    tick;
    i_req = 0; m_gnt = 0;
    rsp(0, 32'h5000_0000, 0);
    samp;
    chk("t5_i_noerr", {i_rvalid_o, i_err_o}, 2'b10);
    tick;
    m_rvalid = 0; m_err = 0; d_req = 1; m_gnt = 1;
    samp;
    tick;
    d_req = 0; i_req = 1;
    samp;
    tick;
    rst_n = 0; m_rvalid = 1; m_rdata = 32'h6000_0000;
    samp;
    chk("t6_in_reset", {m_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o}, 0);
    tick;
    rst_n = 1; i_req = 0; m_gnt = 0;
    samp;
    chk("t6_stray", {i_rvalid_o, d_rvalid_o}, 0);
    tick;
    m_rvalid = 0; d_req = 1; m_gnt = 1;
    samp;
    chk("t6_empty_req", {m_req_o, d_gnt_o}, 2'b11);
    tick;
    samp;
    chk("t6_second", d_gnt_o, 1);
    tick;
    samp;
    chk("t6_full", m_req_o, 0);
    tick;
    d_req = 0; m_gnt = 0;
    rsp(1, 32'h7000_0000, 0);
    samp;
    tick;
    rsp(1, 32'h7000_0001, 0);
    samp;
    tick;
    m_rvalid = 0;
    samp;
    chk("rsp_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
